// File: rtl/level_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : level_writer_if
//  Description : Bundles the byte-stream input handshake and the tile-RAM
//                write port of the level writer.
//                  in_valid/in_ready/in_data/in_last : encoded run stream
//                  wr_en/wr_addr/wr_col/wr_row/wr_data : tile write port
//                modport master : the level writer (accepts runs, drives writes)
//                modport slave  : the environment (level source + tile RAM)
//  Revision    : 1.0  initial release
// ============================================================================
interface level_writer_if #(
    parameter int AW = 9
);
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [4:0]    wr_col;
    logic [3:0]    wr_row;
    logic          wr_data;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_addr, wr_col, wr_row, wr_data
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_addr, wr_col, wr_row, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/level_writer.sv
`default_nettype none
// ============================================================================
//  Module      : level_writer
//  Description : Run-length decoder that fills the level tile map in raster
//                order (column fastest), one tile write per cycle.
//                Each input byte is a run: [7] block type, [6:0] length-1.
//  Ports       : clk     - system clock
//                reset   - asynchronous active-low reset
//                start   - pulse that begins a load (ignored while busy)
//                lw      - level_writer_if.master (run stream + tile writes)
//                busy    - load in progress
//                done    - load finished, held until next start
//                overrun - stream tried to write past the last tile
//                short   - stream ended before the map was full
//  Options     : LEVEL_WRITER_FILL_EN - pad an early-ending stream with air
//  Revision    : 1.0  initial release
// ============================================================================
module level_writer #(
    parameter int COLS = 20,
    parameter int ROWS = 15,
    parameter int AW   = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    level_writer_if.master      lw,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic                short
);

    localparam logic [AW-1:0] c_LastAddr = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] c_AddrOne  = AW'(1);
    localparam logic [4:0]    c_LastCol  = 5'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WRITE = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    // r_addr/r_col/r_row always point at the tile the next write goes to.
    logic [AW-1:0] r_addr;
    logic [4:0]    r_col;
    logic [3:0]    r_row;
    logic [7:0]    r_count;     // tiles left in the current run (1..128)
    logic          r_type;
    logic          r_last;
    logic          r_overrun;
    logic          r_short;

    logic          w_clear;
    logic          w_load;
    logic          w_consume;
    logic          w_advance;
    logic          w_setOverrun;
    logic          w_setShort;
    logic          w_lastTile;
    logic          w_runEnd;

    assign w_lastTile = (r_addr == c_LastAddr);
    assign w_runEnd   = (r_count == 8'd1);

    always_comb begin
        w_nextState  = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_consume    = 1'b0;
        w_advance    = 1'b0;
        w_setOverrun = 1'b0;
        w_setShort   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_nextState = S_FETCH;
                    w_clear     = 1'b1;
                end
            end
            S_FETCH: begin
                if (lw.in_valid) begin
                    w_load      = 1'b1;
                    w_nextState = S_WRITE;
                end
            end
            S_WRITE: begin
                w_consume = 1'b1;
                if (w_lastTile) begin
                    // Map is full: anything still pending in this run, or a
                    // promise of more runs, is discarded and flagged.
                    w_nextState  = S_DONE;
                    w_setOverrun = !w_runEnd || !r_last;
                end else begin
                    w_advance = 1'b1;
                    if (w_runEnd) begin
                        if (!r_last) begin
                            w_nextState = S_FETCH;
                        end else begin
                            w_setShort  = 1'b1;
`ifdef LEVEL_WRITER_FILL_EN
                            w_nextState = S_FILL;
`else
                            w_nextState = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef LEVEL_WRITER_FILL_EN
            S_FILL: begin
                if (w_lastTile) begin
                    w_nextState = S_DONE;
                end else begin
                    w_advance = 1'b1;
                end
            end
`endif
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_count   <= '0;
            r_type    <= 1'b0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
            r_short   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_clear) begin
                r_addr    <= '0;
                r_col     <= '0;
                r_row     <= '0;
                r_overrun <= 1'b0;
                r_short   <= 1'b0;
            end
            if (w_load) begin
                r_type  <= lw.in_data[7];
                r_count <= {1'b0, lw.in_data[6:0]} + 8'd1;
                r_last  <= lw.in_last;
            end
            if (w_consume) begin
                r_count <= r_count - 8'd1;
            end
            // Linear address and col/row tracked side by side, so no
            // row*COLS multiply is needed.
            if (w_advance) begin
                r_addr <= r_addr + c_AddrOne;
                if (r_col == c_LastCol) begin
                    r_col <= '0;
                    r_row <= r_row + 4'd1;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end
            if (w_setOverrun) begin
                r_overrun <= 1'b1;
            end
            if (w_setShort) begin
                r_short <= 1'b1;
            end
        end
    end

    // Outputs decode straight from registers, so they change only on clk.
    assign lw.in_ready = (r_state == S_FETCH);
    assign lw.wr_en    = (r_state == S_WRITE) || (r_state == S_FILL);
    assign lw.wr_data  = (r_state == S_WRITE) ? r_type : 1'b0;
    assign lw.wr_addr  = r_addr;
    assign lw.wr_col   = r_col;
    assign lw.wr_row   = r_row;
    assign busy        = (r_state == S_FETCH) || (r_state == S_WRITE) ||
                         (r_state == S_FILL);
    assign done        = (r_state == S_DONE);
    assign overrun     = r_overrun;
    assign short       = r_short;

endmodule
`default_nettype wire
